display_16hex_monitor: RTL and testbench

- Passive receiver for the labkit hex dot-matrix serial display bus; the other end of the 16-hex-digit display driver.
- Samples disp_clock, disp_data_out, disp_rs, disp_ce_b and disp_reset_b in the clock_27mhz domain.
- Rebuilds the 32-bit control word and decodes each 40-dot character back to its hex nibble.
- Used for loopback self-test and for on-chip checking of what the display actually received.

---
 rtl/display_16hex_monitor.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_display_16hex_monitor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_16hex_monitor.sv
// display_16hex_monitor
// ---------------------
// Passive listener on the labkit hex dot-matrix serial display bus. It
// samples the bus in the clock_27mhz domain, rebuilds the 32-bit control
// word, and decodes every 40-dot character back to the hex nibble that
// the 16-hex-digit display driver meant to show.
//
// Optional build macro: DISP_MON_GLITCH_FILTER_EN
//   When defined, the synchronized disp_clock must hold a level for
//   FILTER_LEN consecutive cycles before it is accepted.
//
// Ports
//   clock_27mhz    in   system clock
//   reset          in   synchronous, active-high reset
//   disp_clock     in   display serial clock (data stable at rising edge)
//   disp_data_out  in   serial data, MSB first
//   disp_rs        in   0 = dot register, 1 = control register
//   disp_ce_b      in   active-low chip enable, rising edge latches
//   disp_reset_b   in   active-low display reset
//   data           out  decoded nibbles, char NUM_CHARS-1 in the MS nibble
//   data_valid     out  one-cycle pulse when data updates
//   blank_mask     out  bit i set = char i was all-zero dots
//   bad_mask       out  bit i set = char i non-zero and matched no glyph
//   control_word   out  last latched control register
//   control_valid  out  one-cycle pulse when control_word updates
//   frame_err      out  one-cycle pulse on a latch with a wrong bit count
module display_16hex_monitor #(
    parameter int NUM_CHARS  = 16,
    parameter int FILTER_LEN = 4
) (
    input  logic                   clock_27mhz,
    input  logic                   reset,
    input  logic                   disp_clock,
    input  logic                   disp_data_out,
    input  logic                   disp_rs,
    input  logic                   disp_ce_b,
    input  logic                   disp_reset_b,
    output logic [4*NUM_CHARS-1:0] data,
    output logic                   data_valid,
    output logic [NUM_CHARS-1:0]   blank_mask,
    output logic [NUM_CHARS-1:0]   bad_mask,
    output logic [31:0]            control_word,
    output logic                   control_valid,
    output logic                   frame_err
);

    localparam int DW         = 4 * NUM_CHARS;
    localparam int FRAME_BITS = 40 * NUM_CHARS;

    // Maps a 40-dot column pattern to {hit, nibble} using the driver's font.
    function automatic logic [4:0] matchGlyph(input logic [39:0] dots);
        case (dots)
            40'h3E5149453E: return 5'h10;
            40'h00427F4000: return 5'h11;
            40'h6251494946: return 5'h12;
            40'h2241494936: return 5'h13;
            40'h1814127F10: return 5'h14;
            40'h2745454539: return 5'h15;
            40'h3C4A494930: return 5'h16;
            40'h0171090503: return 5'h17;
            40'h3649494936: return 5'h18;
            40'h064949291E: return 5'h19;
            40'h7E0909097E: return 5'h1A;
            40'h7F49494936: return 5'h1B;
            40'h3E41414122: return 5'h1C;
            40'h7F4141413E: return 5'h1D;
            40'h7F49494941: return 5'h1E;
            40'h7F09090901: return 5'h1F;
            default:        return 5'h00;
        endcase
    endfunction

    logic clkS1_q, clkS2_q, clkHist_q;
    logic ceS1_q, ceS2_q, ceHist_q;
    logic dinS1_q, dinS2_q;
    logic rsS1_q, rsS2_q;
    logic rstbS1_q, rstbS2_q;

    // Two-flop synchronizers for every bus input, plus edge-history flops.
    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            {clkS1_q, clkS2_q, clkHist_q} <= 3'b000;
            {ceS1_q, ceS2_q, ceHist_q}    <= 3'b000;
            {dinS1_q, dinS2_q}            <= 2'b00;
            {rsS1_q, rsS2_q}              <= 2'b00;
            {rstbS1_q, rstbS2_q}          <= 2'b00;
        end else begin
            clkS1_q   <= disp_clock;
            clkS2_q   <= clkS1_q;
            clkHist_q <= clkS2_q;
            ceS1_q    <= disp_ce_b;
            ceS2_q    <= ceS1_q;
            ceHist_q  <= ceS2_q;
            dinS1_q   <= disp_data_out;
            dinS2_q   <= dinS1_q;
            rsS1_q    <= disp_rs;
            rsS2_q    <= rsS1_q;
            rstbS1_q  <= disp_reset_b;
            rstbS2_q  <= rstbS1_q;
        end
    end

    logic rclk;
    logic ceRise;

`ifdef DISP_MON_GLITCH_FILTER_EN
    logic       filtLevel_q, filtHist_q;
    logic [7:0] filtCnt_q;

    // The filtered level only flips after FILTER_LEN consecutive samples
    // disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            filtLevel_q <= 1'b0;
            filtHist_q  <= 1'b0;
            filtCnt_q   <= 8'd0;
        end else begin
            filtHist_q <= filtLevel_q;
            if (clkS2_q == filtLevel_q) begin
                filtCnt_q <= 8'd0;
            end else if (filtCnt_q == 8'(FILTER_LEN - 1)) begin
                filtLevel_q <= clkS2_q;
                filtCnt_q   <= 8'd0;
            end else begin
                filtCnt_q <= filtCnt_q + 8'd1;
            end
        end
    end

    assign rclk = filtLevel_q & ~filtHist_q;
`else
    assign rclk = clkS2_q & ~clkHist_q;
`endif

    assign ceRise = ceS2_q & ~ceHist_q;

    logic [9:0]           bitCnt_q, bitCnt_d;
    logic [5:0]           dotCnt_q, dotCnt_d;
    logic [38:0]          charShift_q, charShift_d;
    logic [31:0]          ctrlShift_q, ctrlShift_d;
    logic                 lastRs_q, lastRs_d;
    logic [39:0]          charWord_q, charWord_d;
    logic                 decPend_q, decPend_d;
    logic [DW-1:0]        nibAcc_q, nibAcc_d;
    logic [NUM_CHARS-1:0] blankAcc_q, blankAcc_d;
    logic [NUM_CHARS-1:0] badAcc_q, badAcc_d;
    logic [DW-1:0]        data_q, data_d;
    logic [NUM_CHARS-1:0] blankMask_q, blankMask_d;
    logic [NUM_CHARS-1:0] badMask_q, badMask_d;
    logic [31:0]          controlWord_q, controlWord_d;
    logic                 dataValid_q, dataValid_d;
    logic                 controlValid_q, controlValid_d;
    logic                 frameErr_q, frameErr_d;

    logic [4:0]           glyphHit;
    logic                 charBlank;
    logic                 charBad;
    logic [3:0]           charNib;
    logic [DW-1:0]        nibAccNext;
    logic [NUM_CHARS-1:0] blankAccNext;
    logic [NUM_CHARS-1:0] badAccNext;

    // Decode of the character captured on the previous rclk. The "Next"
    // accumulators fold in a pending decode so a latch arriving on that
    // same cycle still sees the final character.
    always_comb begin
        glyphHit     = matchGlyph(charWord_q);
        charBlank    = (charWord_q == 40'd0);
        charBad      = !charBlank && !glyphHit[4];
        charNib      = glyphHit[4] ? glyphHit[3:0] : 4'h0;
        nibAccNext   = nibAcc_q;
        blankAccNext = blankAcc_q;
        badAccNext   = badAcc_q;
        if (decPend_q) begin
            nibAccNext   = {nibAcc_q[DW-5:0], charNib};
            blankAccNext = {blankAcc_q[NUM_CHARS-2:0], charBlank};
            badAccNext   = {badAcc_q[NUM_CHARS-2:0], charBad};
        end
    end

    // Frame assembly and latch. Priority: display reset, then chip-enable
    // release (which swallows a simultaneous rclk), then shifting a bit.
    always_comb begin
        bitCnt_d       = bitCnt_q;
        dotCnt_d       = dotCnt_q;
        charShift_d    = charShift_q;
        ctrlShift_d    = ctrlShift_q;
        lastRs_d       = lastRs_q;
        charWord_d     = charWord_q;
        decPend_d      = 1'b0;
        nibAcc_d       = nibAccNext;
        blankAcc_d     = blankAccNext;
        badAcc_d       = badAccNext;
        data_d         = data_q;
        blankMask_d    = blankMask_q;
        badMask_d      = badMask_q;
        controlWord_d  = controlWord_q;
        dataValid_d    = 1'b0;
        controlValid_d = 1'b0;
        frameErr_d     = 1'b0;

        if (!rstbS2_q) begin
            bitCnt_d    = 10'd0;
            dotCnt_d    = 6'd0;
            charShift_d = 39'd0;
            nibAcc_d    = '0;
            blankAcc_d  = '0;
            badAcc_d    = '0;
        end else if (ceRise) begin
            if (bitCnt_q != 10'd0) begin
                if (lastRs_q) begin
                    if (bitCnt_q == 10'd32) begin
                        controlWord_d  = ctrlShift_q;
                        controlValid_d = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end else if (int'(bitCnt_q) == FRAME_BITS) begin
                    data_d      = nibAccNext;
                    blankMask_d = blankAccNext;
                    badMask_d   = badAccNext;
                    dataValid_d = 1'b1;
                end else begin
                    frameErr_d = 1'b1;
                end
            end
            bitCnt_d    = 10'd0;
            dotCnt_d    = 6'd0;
            charShift_d = 39'd0;
            nibAcc_d    = '0;
            blankAcc_d  = '0;
            badAcc_d    = '0;
        end else if (rclk && !ceS2_q) begin
            if (bitCnt_q != 10'd1023) begin
                bitCnt_d = bitCnt_q + 10'd1;
            end
            lastRs_d = rsS2_q;
            if (rsS2_q) begin
                ctrlShift_d = {ctrlShift_q[30:0], dinS2_q};
            end else begin
                charShift_d = {charShift_q[37:0], dinS2_q};
                if (dotCnt_q == 6'd39) begin
                    dotCnt_d   = 6'd0;
                    charWord_d = {charShift_q, dinS2_q};
                    decPend_d  = 1'b1;
                end else begin
                    dotCnt_d = dotCnt_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            bitCnt_q       <= 10'd0;
            dotCnt_q       <= 6'd0;
            charShift_q    <= 39'd0;
            ctrlShift_q    <= 32'd0;
            lastRs_q       <= 1'b0;
            charWord_q     <= 40'd0;
            decPend_q      <= 1'b0;
            nibAcc_q       <= '0;
            blankAcc_q     <= '0;
            badAcc_q       <= '0;
            data_q         <= '0;
            blankMask_q    <= '1;
            badMask_q      <= '0;
            controlWord_q  <= 32'd0;
            dataValid_q    <= 1'b0;
            controlValid_q <= 1'b0;
            frameErr_q     <= 1'b0;
        end else begin
            bitCnt_q       <= bitCnt_d;
            dotCnt_q       <= dotCnt_d;
            charShift_q    <= charShift_d;
            ctrlShift_q    <= ctrlShift_d;
            lastRs_q       <= lastRs_d;
            charWord_q     <= charWord_d;
            decPend_q      <= decPend_d;
            nibAcc_q       <= nibAcc_d;
            blankAcc_q     <= blankAcc_d;
            badAcc_q       <= badAcc_d;
            data_q         <= data_d;
            blankMask_q    <= blankMask_d;
            badMask_q      <= badMask_d;
            controlWord_q  <= controlWord_d;
            dataValid_q    <= dataValid_d;
            controlValid_q <= controlValid_d;
            frameErr_q     <= frameErr_d;
        end
    end

    assign data          = data_q;
    assign data_valid    = dataValid_q;
    assign blank_mask    = blankMask_q;
    assign bad_mask      = badMask_q;
    assign control_word  = controlWord_q;
    assign control_valid = controlValid_q;
    assign frame_err     = frameErr_q;

endmodule

// File: tb/tb_display_16hex_monitor.sv
// tb_display_16hex_monitor
// ------------------------
// Drives the display serial bus the way the 16-hex-digit driver does and
// checks what the monitor rebuilds: a table of whole frames plus a few
// hand-written sequences for latch latency, display reset and system
// reset in the middle of a frame.
module tb_display_16hex_monitor;

    localparam int LOWC  = 5;
    localparam int HIGHC = 5;

`ifdef DISP_MON_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clock_27mhz = 1'b0;
    logic        reset = 1'b1;
    logic        disp_clock = 1'b0;
    logic        disp_data_out = 1'b0;
    logic        disp_rs = 1'b0;
    logic        disp_ce_b = 1'b1;
    logic        disp_reset_b = 1'b1;
    logic [63:0] data;
    logic        data_valid;
    logic [15:0] blank_mask;
    logic [15:0] bad_mask;
    logic [31:0] control_word;
    logic        control_valid;
    logic        frame_err;

    display_16hex_monitor #(.NUM_CHARS(16), .FILTER_LEN(4)) dut (
        .clock_27mhz  (clock_27mhz),
        .reset        (reset),
        .disp_clock   (disp_clock),
        .disp_data_out(disp_data_out),
        .disp_rs      (disp_rs),
        .disp_ce_b    (disp_ce_b),
        .disp_reset_b (disp_reset_b),
        .data         (data),
        .data_valid   (data_valid),
        .blank_mask   (blank_mask),
        .bad_mask     (bad_mask),
        .control_word (control_word),
        .control_valid(control_valid),
        .frame_err    (frame_err)
    );

    always #5 clock_27mhz = ~clock_27mhz;

    int vecCount = 0;
    int checkCount = 0;
    int miscompares = 0;
    int dvSeen = 0;
    int cvSeen = 0;
    int feSeen = 0;

    // Pulse counters, sampled on the falling edge away from the DUT update.
    always @(negedge clock_27mhz) begin
        if (data_valid)    dvSeen++;
        if (control_valid) cvSeen++;
        if (frame_err)     feSeen++;
    end

    typedef struct {
        string        name;
        logic         rs;
        int           nbits;
        logic [639:0] bits;
        int           glitchAt;
        int           expDv;
        int           expCv;
        int           expFe;
        logic [63:0]  expData;
        logic [15:0]  expBlank;
        logic [15:0]  expBad;
        logic [31:0]  expCtrl;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [39:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 40'h3E5149453E;
            4'h1: return 40'h00427F4000;
            4'h2: return 40'h6251494946;
            4'h3: return 40'h2241494936;
            4'h4: return 40'h1814127F10;
            4'h5: return 40'h2745454539;
            4'h6: return 40'h3C4A494930;
            4'h7: return 40'h0171090503;
            4'h8: return 40'h3649494936;
            4'h9: return 40'h064949291E;
            4'hA: return 40'h7E0909097E;
            4'hB: return 40'h7F49494936;
            4'hC: return 40'h3E41414122;
            4'hD: return 40'h7F4141413E;
            4'hE: return 40'h7F49494941;
            default: return 40'h7F09090901;
        endcase
    endfunction

    function automatic logic [639:0] encode(input logic [63:0] d);
        logic [639:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) begin
            f[40*i +: 40] = glyph(d[4*i +: 4]);
        end
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic openFrame(input logic rs);
        @(negedge clock_27mhz);
        disp_rs   = rs;
        disp_ce_b = 1'b0;
        repeat (4) @(negedge clock_27mhz);
    endtask

    // Sends bits[n-1] down to bits[0]; glitchAt >= 0 inserts a 2-cycle
    // disp_clock high pulse inside the low phase of that bit.
    task automatic sendBits(input logic [639:0] bits, input int n, input int glitchAt);
        for (int i = n - 1; i >= 0; i--) begin
            disp_data_out = bits[i];
            disp_clock    = 1'b0;
            if ((n - 1 - i) == glitchAt) begin
                repeat (2) @(negedge clock_27mhz);
                disp_clock = 1'b1;
                repeat (2) @(negedge clock_27mhz);
                disp_clock = 1'b0;
            end
            repeat (LOWC) @(negedge clock_27mhz);
            disp_clock = 1'b1;
            repeat (HIGHC) @(negedge clock_27mhz);
        end
        disp_clock = 1'b0;
    endtask

    task automatic closeFrame();
        repeat (8) @(negedge clock_27mhz);
        disp_ce_b = 1'b1;
        repeat (10) @(negedge clock_27mhz);
    endtask

    task automatic applyStimulus(input vec_t v);
        openFrame(v.rs);
        sendBits(v.bits, v.nbits, v.glitchAt);
        closeFrame();
    endtask

    task automatic checkPulses(input string name, input int dv0, input int cv0,
                               input int fe0, input int edv, input int ecv, input int efe);
        checkOutput({name, " data_valid count"},    64'(dvSeen - dv0), 64'(edv));
        checkOutput({name, " control_valid count"}, 64'(cvSeen - cv0), 64'(ecv));
        checkOutput({name, " frame_err count"},     64'(feSeen - fe0), 64'(efe));
    endtask

    task automatic checkState(input string name, input logic [63:0] d,
                              input logic [15:0] bl, input logic [15:0] bd,
                              input logic [31:0] cw);
        checkOutput({name, " data"},         data,         d);
        checkOutput({name, " blank_mask"},   64'(blank_mask),   64'(bl));
        checkOutput({name, " bad_mask"},     64'(bad_mask),     64'(bd));
        checkOutput({name, " control_word"}, 64'(control_word), 64'(cw));
    endtask

    initial begin
        int dv0, cv0, fe0;
        logic [639:0] f;

        // ---- table of whole frames ----
        vecs[0] = '{"init", 1'b0, 640, '0, -1, 1, 0, 0,
                    64'h0, 16'hFFFF, 16'h0, 32'h0};
        vecs[1] = '{"ctrl", 1'b1, 32, 640'(32'h7F7F7F7F), -1, 0, 1, 0,
                    64'h0, 16'hFFFF, 16'h0, 32'h7F7F7F7F};
        vecs[2] = '{"hex", 1'b0, 640, encode(64'h0123456789ABCDEF), -1, 1, 0, 0,
                    64'h0123456789ABCDEF, 16'h0, 16'h0, 32'h7F7F7F7F};
        f = encode(64'h0123456789ABCDEF);
        f[120 +: 40] = 40'h0102040810;
        vecs[3] = '{"badchar", 1'b0, 640, f, -1, 1, 0, 0,
                    64'h0123456789AB0DEF, 16'h0, 16'h0008, 32'h7F7F7F7F};
        f = encode(64'hFEDCBA9876543210) >> 40;
        vecs[4] = '{"abort600", 1'b0, 600, f, -1, 0, 0, 1,
                    64'h0123456789AB0DEF, 16'h0, 16'h0008, 32'h7F7F7F7F};
        vecs[5] = '{"ctrl31", 1'b1, 31, 640'(32'hDEADBEEF), -1, 0, 0, 1,
                    64'h0123456789AB0DEF, 16'h0, 16'h0008, 32'h7F7F7F7F};
        f = encode(64'hFEDCBA9876543210);
        f[600 +: 40] = 40'h0;
        f[0 +: 40]   = 40'h0;
        vecs[6] = '{"blanks", 1'b0, 640, f, -1, 1, 0, 0,
                    64'h0EDCBA9876543210, 16'h8001, 16'h0, 32'h7F7F7F7F};
        if (FILT)
            vecs[7] = '{"glitch", 1'b0, 640, encode(64'h13579BDF02468ACE), 100, 1, 0, 0,
                        64'h13579BDF02468ACE, 16'h0, 16'h0, 32'h7F7F7F7F};
        else
            vecs[7] = '{"glitch", 1'b0, 640, encode(64'h13579BDF02468ACE), 100, 0, 0, 1,
                        64'h0EDCBA9876543210, 16'h8001, 16'h0, 32'h7F7F7F7F};

        // ---- reset state ----
        repeat (4) @(negedge clock_27mhz);
        vecCount++;
        checkState("reset", 64'h0, 16'hFFFF, 16'h0, 32'h0);
        checkOutput("reset pulses", {61'd0, data_valid, control_valid, frame_err}, 64'h0);
        reset = 1'b0;

        // Driver init: display reset pulse, then the all-zero frame.
        @(negedge clock_27mhz);
        disp_reset_b = 1'b0;
        repeat (10) @(negedge clock_27mhz);
        disp_reset_b = 1'b1;
        repeat (6) @(negedge clock_27mhz);

        for (int k = 0; k < 8; k++) begin
            dv0 = dvSeen; cv0 = cvSeen; fe0 = feSeen;
            applyStimulus(vecs[k]);
            vecCount++;
            checkPulses(vecs[k].name, dv0, cv0, fe0,
                        vecs[k].expDv, vecs[k].expCv, vecs[k].expFe);
            checkState(vecs[k].name, vecs[k].expData, vecs[k].expBlank,
                       vecs[k].expBad, vecs[k].expCtrl);
        end

        // ---- chip-enable toggle with no bits: silent ----
        dv0 = dvSeen; cv0 = cvSeen; fe0 = feSeen;
        openFrame(1'b1);
        closeFrame();
        vecCount++;
        checkPulses("empty", dv0, cv0, fe0, 0, 0, 0);

        // ---- control latch latency: pulse on 3rd edge after ce_b high ----
        openFrame(1'b1);
        sendBits(640'(32'hA5A50FF0), 32, -1);
        repeat (8) @(negedge clock_27mhz);
        disp_ce_b = 1'b1;
        repeat (2) @(negedge clock_27mhz);
        vecCount++;
        checkOutput("latency edge2 control_valid", 64'(control_valid), 64'h0);
        @(negedge clock_27mhz);
        checkOutput("latency edge3 control_valid", 64'(control_valid), 64'h1);
        checkOutput("latency control_word", 64'(control_word), 64'hA5A50FF0);
        @(negedge clock_27mhz);
        checkOutput("latency edge4 control_valid", 64'(control_valid), 64'h0);
        repeat (6) @(negedge clock_27mhz);

        // ---- display reset mid-frame, then a full frame ----
        dv0 = dvSeen; cv0 = cvSeen; fe0 = feSeen;
        openFrame(1'b0);
        sendBits(encode(64'h1111111111111111) >> 340, 300, -1);
        disp_reset_b = 1'b0;
        repeat (10) @(negedge clock_27mhz);
        disp_reset_b = 1'b1;
        repeat (6) @(negedge clock_27mhz);
        sendBits(encode(64'h89ABCDEF01234567), 640, -1);
        closeFrame();
        vecCount++;
        checkPulses("dispreset", dv0, cv0, fe0, 1, 0, 0);
        checkState("dispreset", 64'h89ABCDEF01234567, 16'h0, 16'h0, 32'hA5A50FF0);

        // ---- system reset mid-frame, then a full frame ----
        dv0 = dvSeen; cv0 = cvSeen; fe0 = feSeen;
        openFrame(1'b0);
        sendBits(encode(64'h2222222222222222) >> 440, 200, -1);
        reset = 1'b1;
        repeat (3) @(negedge clock_27mhz);
        reset = 1'b0;
        vecCount++;
        checkState("sysreset", 64'h0, 16'hFFFF, 16'h0, 32'h0);
        repeat (4) @(negedge clock_27mhz);
        sendBits(encode(64'hC0FFEE0012345678), 640, -1);
        closeFrame();
        checkPulses("sysreset", dv0, cv0, fe0, 1, 0, 0);
        checkState("sysreset frame", 64'hC0FFEE0012345678, 16'h0, 16'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, miscompares);
        $finish;
    end

endmodule
